// File: rtl/lsu_bus_pkg.sv
// Shared types, default address windows and window-match helper for the LSU request demux.
package lsu_bus_pkg;

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} demux_state_e;
    typedef enum logic {TGT_RAM, TGT_MMIO} tgt_e;

    localparam logic [31:0] MMIO_BASE_DEF = 32'h4000_0000;
    localparam logic [31:0] MMIO_SIZE_DEF = 32'h0001_0000;
    localparam logic [31:0] RAM_BASE_DEF  = 32'h0000_0000;
    localparam logic [31:0] RAM_SIZE_DEF  = 32'h0001_0000;
    localparam int unsigned MAX_OUT_DEF   = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } lsu_req_t;

    // Subtracting first keeps the upper bound check free of 32-bit overflow.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/lsu_addr_decode.sv
// Address -> target port decode. With LSU_DEMUX2_DECERR_EN defined, addresses outside
// both windows raise decerr_o; otherwise everything outside MMIO goes to RAM.
module lsu_addr_decode
    import lsu_bus_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter logic [31:0] MMIO_SIZE = MMIO_SIZE_DEF,
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
    parameter logic [31:0] RAM_SIZE  = RAM_SIZE_DEF
) (
    input  logic [31:0] addr_i,
    output tgt_e        tgt_o,
    output logic        decerr_o
);

    logic mmio_hit;

    assign mmio_hit = in_window(addr_i, MMIO_BASE, MMIO_SIZE);
    assign tgt_o    = mmio_hit ? TGT_MMIO : TGT_RAM;

`ifdef LSU_DEMUX2_DECERR_EN
    assign decerr_o = ~mmio_hit & ~in_window(addr_i, RAM_BASE, RAM_SIZE);
`else
    assign decerr_o = 1'b0;
`endif

    // Windows must be non-empty, MMIO a power of two, and neither may wrap past 2^32.
    if (MMIO_SIZE == 32'd0 || (MMIO_SIZE & (MMIO_SIZE - 32'd1)) != 32'd0 ||
        (MMIO_SIZE - 32'd1) > ~MMIO_BASE ||
        RAM_SIZE == 32'd0 || (RAM_SIZE - 32'd1) > ~RAM_BASE) begin : g_bad_cfg
        $error("lsu_addr_decode: invalid address window parameters");
    end

endmodule

// File: rtl/lsu_req_demux2.sv
// 1-to-2 LSU request router (port 0 RAM, port 1 MMIO) with outstanding count and
// registered in-order response merge. Optional decode errors: LSU_DEMUX2_DECERR_EN.
module lsu_req_demux2
    import lsu_bus_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter logic [31:0] MMIO_SIZE = MMIO_SIZE_DEF,
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
    parameter logic [31:0] RAM_SIZE  = RAM_SIZE_DEF,
    parameter int unsigned MAX_OUT   = MAX_OUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        p0_req_valid,
    input  logic        p0_req_ready,
    output logic [31:0] p0_req_addr,
    output logic        p0_req_we,
    output logic [3:0]  p0_req_wstrb,
    output logic [31:0] p0_req_wdata,
    input  logic        p0_rsp_valid,
    input  logic [31:0] p0_rsp_rdata,
    output logic        p1_req_valid,
    input  logic        p1_req_ready,
    output logic [31:0] p1_req_addr,
    output logic        p1_req_we,
    output logic [3:0]  p1_req_wstrb,
    output logic [31:0] p1_req_wdata,
    input  logic        p1_rsp_valid,
    input  logic [31:0] p1_rsp_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        err_spurious
);

    localparam logic [3:0] CNT_MAX = 4'(MAX_OUT);

    if (MAX_OUT < 1 || MAX_OUT > 15) begin : g_bad_max_out
        $error("lsu_req_demux2: MAX_OUT must be 1..15");
    end

    demux_state_e state_q;
    logic [3:0]   cnt_q, cnt_d;
    logic         rsp_valid_q, rsp_err_q, err_spurious_q;
    logic [31:0]  rsp_rdata_q;

    tgt_e     tgt;
    logic     decerr, sel, stall, dn_ready, fwd, fwd_acc, err_acc, ret, spur;
    lsu_req_t req_pl;

    lsu_addr_decode #(
        .MMIO_BASE (MMIO_BASE),
        .MMIO_SIZE (MMIO_SIZE),
        .RAM_BASE  (RAM_BASE),
        .RAM_SIZE  (RAM_SIZE)
    ) u_dec (
        .addr_i   (req_addr),
        .tgt_o    (tgt),
        .decerr_o (decerr)
    );

    assign sel = (tgt == TGT_MMIO);

    // Only one target in flight at a time keeps responses in request order.
    assign stall = (cnt_q == CNT_MAX)
                 | ((state_q == BUSY0) & sel)
                 | ((state_q == BUSY1) & ~sel)
                 | (decerr & (state_q != IDLE));

    assign dn_ready  = decerr | (sel ? p1_req_ready : p0_req_ready);
    assign req_ready = rst_n & ~stall & dn_ready;
    assign fwd       = rst_n & req_valid & ~stall & ~decerr;
    assign fwd_acc   = fwd & dn_ready;
    assign err_acc   = req_valid & req_ready & decerr;

    assign ret  = ((state_q == BUSY0) & p0_rsp_valid) | ((state_q == BUSY1) & p1_rsp_valid);
    assign spur = (p0_rsp_valid & (state_q != BUSY0)) | (p1_rsp_valid & (state_q != BUSY1));

    assign req_pl = '{addr: req_addr, we: req_we, wstrb: req_wstrb, wdata: req_wdata};

    assign p0_req_valid = fwd & ~sel;
    assign p1_req_valid = fwd & sel;
    assign p0_req_addr  = req_pl.addr;
    assign p0_req_we    = req_pl.we;
    assign p0_req_wstrb = req_pl.wstrb;
    assign p0_req_wdata = req_pl.wdata;
    assign p1_req_addr  = req_pl.addr;
    assign p1_req_we    = req_pl.we;
    assign p1_req_wstrb = req_pl.wstrb;
    assign p1_req_wdata = req_pl.wdata;

    always_comb begin
        cnt_d = cnt_q;
        if (fwd_acc && !ret)
            cnt_d = cnt_q + 4'd1;
        else if (ret && !fwd_acc)
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 32'd0;
            rsp_err_q      <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == 4'd0)
                state_q <= IDLE;
            else if (state_q == IDLE && fwd_acc)
                state_q <= sel ? BUSY1 : BUSY0;

            rsp_valid_q <= ret | err_acc;
            rsp_err_q   <= err_acc;
            if (ret)
                rsp_rdata_q <= (state_q == BUSY1) ? p1_rsp_rdata : p0_rsp_rdata;
            else if (err_acc)
                rsp_rdata_q <= 32'd0;

            if (spur)
                err_spurious_q <= 1'b1;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign err_spurious = err_spurious_q;

endmodule
